// File: rtl/linear_interpolator_if.sv
// Sample stream interface for linear_interpolator.
// The master drives the input sample, its strobe, the factor k and the
// downstream tick. The slave is the interpolator and drives in_ready,
// sample_out, rdy_out and overrun.
// When ZOH_MODE_EN is defined, the interface also carries the zoh select bit.
interface linear_interpolator_if #(
    parameter int BITS_ADC  = 8,
    parameter int BITS_ACUM = 12
);
    localparam int KW = $clog2(BITS_ACUM - BITS_ADC + 1);

    logic [KW-1:0]       k;
    logic [BITS_ADC-1:0] sample_in;
    logic                rdy_in;
    logic                in_ready;
    logic                out_tick;
    logic [BITS_ADC-1:0] sample_out;
    logic                rdy_out;
    logic                overrun;
`ifdef ZOH_MODE_EN
    logic                zoh;
`endif

    modport master (
`ifdef ZOH_MODE_EN
        output zoh,
`endif
        output k, sample_in, rdy_in, out_tick,
        input  in_ready, sample_out, rdy_out, overrun
    );

    modport slave (
`ifdef ZOH_MODE_EN
        input  zoh,
`endif
        input  k, sample_in, rdy_in, out_tick,
        output in_ready, sample_out, rdy_out, overrun
    );
endinterface

// File: rtl/linear_interpolator.sv
// linear_interpolator: expands each accepted input sample into 2^k output
// samples. The outputs ramp linearly from the previous input sample to the
// new one, and each output is paced by a downstream out_tick.
// The accumulator holds sample << k_lat. Each output is the floor of the
// accumulator shifted back down, so the last output of a burst lands exactly
// on the new sample.
// Optional build macro: ZOH_MODE_EN adds a zoh select bit. When zoh is set,
// the block holds the new sample for the whole burst (zero-order hold).
module linear_interpolator #(
    parameter int BITS_ADC  = 8,
    parameter int BITS_ACUM = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    linear_interpolator_if.slave bus
);
    localparam int D  = BITS_ACUM - BITS_ADC;
    localparam int KW = $clog2(D + 1);
    localparam int CW = $clog2((1 << D) + 1);
    localparam int AW = BITS_ACUM + 1;
    localparam int DW = BITS_ADC + 1;
    localparam logic [KW-1:0] K_MAX = KW'(D);

    // Limit the requested log2 factor to what the accumulator can hold.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k_raw);
        if (k_raw > K_MAX) begin
            clamp_k = K_MAX;
        end else begin
            clamp_k = k_raw;
        end
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        INTERP = 1'b1
    } state_t;

    state_t                 state_r;
    logic [BITS_ADC-1:0]    prev_r;
    logic                   prev_valid_r;
    logic signed [AW-1:0]   acc_r;
    logic signed [DW-1:0]   delta_r;
    logic [CW-1:0]          cnt_r;
    logic [KW-1:0]          k_lat_r;

    logic [KW-1:0]          k_clamped_s;
    logic [AW-1:0]          in_ext_s;
    logic [AW-1:0]          prev_ext_s;
    logic signed [DW-1:0]   delta_new_s;
    logic signed [AW-1:0]   acc_next_s;
    logic                   hold_s;

    // Acceptance-time operands and the accumulator value after the next tick.
    always_comb begin
        k_clamped_s = clamp_k(bus.k);
        in_ext_s    = {{(AW-BITS_ADC){1'b0}}, bus.sample_in};
        prev_ext_s  = {{(AW-BITS_ADC){1'b0}}, prev_r};
        delta_new_s = $signed({1'b0, bus.sample_in}) - $signed({1'b0, prev_r});
        acc_next_s  = acc_r + {{(AW-DW){delta_r[DW-1]}}, delta_r};
`ifdef ZOH_MODE_EN
        hold_s      = ~prev_valid_r | bus.zoh;
`else
        hold_s      = ~prev_valid_r;
`endif
    end

    // Control FSM: accept a sample in IDLE, then step the ramp on each tick in INTERP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            prev_r         <= {BITS_ADC{1'b0}};
            prev_valid_r   <= 1'b0;
            acc_r          <= {AW{1'b0}};
            delta_r        <= {DW{1'b0}};
            cnt_r          <= {CW{1'b0}};
            k_lat_r        <= {KW{1'b0}};
            bus.in_ready   <= 1'b1;
            bus.rdy_out    <= 1'b0;
            bus.sample_out <= {BITS_ADC{1'b0}};
            bus.overrun    <= 1'b0;
        end else begin
            bus.rdy_out    <= 1'b0;
            bus.sample_out <= {BITS_ADC{1'b0}};
            bus.overrun    <= 1'b0;
            case (state_r)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.rdy_in) begin
                        k_lat_r      <= k_clamped_s;
                        prev_r       <= bus.sample_in;
                        prev_valid_r <= 1'b1;
                        cnt_r        <= {{(CW-1){1'b0}}, 1'b1} << k_clamped_s;
                        if (hold_s) begin
                            delta_r <= {DW{1'b0}};
                            acc_r   <= $signed(in_ext_s << k_clamped_s);
                        end else begin
                            delta_r <= delta_new_s;
                            acc_r   <= $signed(prev_ext_s << k_clamped_s);
                        end
                        bus.in_ready <= 1'b0;
                        state_r      <= INTERP;
                    end
                end
                INTERP: begin
                    // A sample offered mid-burst is dropped and flagged.
                    if (bus.rdy_in) begin
                        bus.overrun <= 1'b1;
                    end
                    if (bus.out_tick) begin
                        acc_r          <= acc_next_s;
                        cnt_r          <= cnt_r - CW'(1);
                        bus.rdy_out    <= 1'b1;
                        bus.sample_out <= BITS_ADC'(acc_next_s >>> k_lat_r);
                        if (cnt_r == CW'(1)) begin
                            state_r      <= IDLE;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
